imc_arbiter: RTL and testbench

IMC_ARBITER -- requirements
Module: imc_arbiter

---
 rtl/imc_arbiter.sv | 154 +++++++++++++++
 tb/tb_imc_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imc_arbiter.sv
// ---------------------------------------------------------------------------
// imc_arbiter
//   Two-requester round-robin arbiter that hands the shared in-memory-compute
//   (IMC) engine to one input wrapper at a time. It sequences
//   IDLE -> GRANT -> START -> WAIT -> RELEASE, pulses the IMC start, waits for
//   the IMC completion and then pulses done back to the owner.
//
//   Optional feature: define IMC_ARB_WATCHDOG_EN to build a WAIT-state
//   watchdog. It aborts a transaction after TIMEOUT_CYCLES WAIT cycles
//   without imc_done_i. Without the macro, err_o is tied low and WAIT waits
//   forever.
//
// Ports
//   clk_i        : clock, rising edge
//   rstn_i       : asynchronous active-low reset
//   req_i[1:0]   : per-requester request level
//   imc_done_i   : one-cycle IMC completion pulse (only honoured in WAIT)
//   gnt_o[1:0]   : one-hot grant, high in GRANT/START/WAIT
//   sel_o        : operand/result mux select (current owner)
//   imc_start_o  : one-cycle IMC start pulse (START state)
//   done_o[1:0]  : one-cycle completion pulse to the owner (RELEASE state)
//   busy_o       : high whenever the FSM is not IDLE
//   err_o        : one-cycle watchdog abort pulse (RELEASE after timeout)
// ---------------------------------------------------------------------------
module imc_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] req_i,
  input  logic       imc_done_i,
  output logic [1:0] gnt_o,
  output logic       sel_o,
  output logic       imc_start_o,
  output logic [1:0] done_o,
  output logic       busy_o,
  output logic       err_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("imc_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_RELEASE
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;   // last requester served

`ifdef IMC_ARB_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       abort_q,  abort_d;  // high only in a RELEASE caused by timeout
`endif

  // Round-robin pick: on a tie the requester that was not served last wins,
  // otherwise the single active bit wins. Only used when |req_i.
  logic winner;
  assign winner = (&req_i) ? ~last_q : req_i[1];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // that is what keeps this block free of inferred latches.
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef IMC_ARB_WATCHDOG_EN
    wd_cnt_d = wd_cnt_q;
    abort_d  = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d = winner;
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = S_START;
      S_START: begin
        state_d = S_WAIT;
`ifdef IMC_ARB_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
`ifdef IMC_ARB_WATCHDOG_EN
        wd_cnt_d = wd_cnt_q + 8'd1;
`endif
        // A completion in the very cycle the count reaches the limit wins,
        // giving a clean finish rather than an abort.
        if (imc_done_i) begin
          state_d = S_RELEASE;
        end
`ifdef IMC_ARB_WATCHDOG_EN
        // wd_cnt_q counts WAIT cycles already elapsed; this cycle makes the
        // count reach TIMEOUT_CYCLES.
        else if (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_RELEASE;
          abort_d = 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // requester 0 has first priority out of reset
`ifdef IMC_ARB_WATCHDOG_EN
      wd_cnt_q <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all flops update together from the
      // values computed before this edge.
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef IMC_ARB_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
      abort_q  <= abort_d;
`endif
    end
  end

  // Outputs depend on registered state only, never on an input.
  logic gnt_phase;
  assign gnt_phase   = (state_q == S_GRANT) || (state_q == S_START) ||
                       (state_q == S_WAIT);
  assign gnt_o       = gnt_phase ? (2'b01 << owner_q) : 2'b00;
  assign done_o      = (state_q == S_RELEASE) ? (2'b01 << owner_q) : 2'b00;
  assign sel_o       = owner_q;
  assign imc_start_o = (state_q == S_START);
  assign busy_o      = (state_q != S_IDLE);
`ifdef IMC_ARB_WATCHDOG_EN
  assign err_o       = (state_q == S_RELEASE) && abort_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_imc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imc_arbiter
//   Scoreboard bench for imc_arbiter. The driver plans each transaction from
//   the arbitration rules (round-robin pick, fixed phase timeline, optional
//   watchdog) and pushes the events it expects -- grant, start, done, return
//   to idle -- with their cycle numbers. An independent monitor turns DUT
//   output edges into events and compares them against the queue.
//   Build with IMC_ARB_WATCHDOG_EN defined to exercise the watchdog
//   (TIMEOUT_CYCLES = 4).
// ---------------------------------------------------------------------------
module tb_imc_arbiter;

`ifdef IMC_ARB_WATCHDOG_EN
  localparam int T_OUT = 4;
  localparam bit WD_ON = 1'b1;
`else
  localparam int T_OUT = 255;
  localparam bit WD_ON = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [1:0] req_i;
  logic       imc_done_i;
  logic [1:0] gnt_o;
  logic       sel_o;
  logic       imc_start_o;
  logic [1:0] done_o;
  logic       busy_o;
  logic       err_o;

  imc_arbiter #(.TIMEOUT_CYCLES(T_OUT)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_i       (req_i),
    .imc_done_i  (imc_done_i),
    .gnt_o       (gnt_o),
    .sel_o       (sel_o),
    .imc_start_o (imc_start_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef enum int {EV_GRANT, EV_START, EV_DONE, EV_IDLE} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [2:0] val;
    int         cy;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  bit  last_m = 1'b1;  // model's last-served requester

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack(input ev_kind_e k, input logic [2:0] v,
                                       input int cy);
    return {16'd0, 32'(cy), 8'(int'(k)), 5'd0, v};
  endfunction

  function automatic bit pick(input logic [1:0] r, input bit last);
    if (r == 2'b11) return ~last;
    return r[1];
  endfunction

  function automatic logic [1:0] onehot(input bit w);
    return w ? 2'b10 : 2'b01;
  endfunction

  task automatic expect_ev(input ev_kind_e k, input logic [2:0] v, input int cy);
    ev_t e;
    e.kind = k; e.val = v; e.cy = cy;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic [1:0] prev_gnt  = 2'b00;
  logic       prev_busy = 1'b0;

  task automatic observe(input ev_kind_e k, input logic [2:0] v);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %0h at cycle %0d, expected none",
               int'(k), v, cyc);
    end else begin
      e = sb.pop_front();
      check($sformatf("event_k%0d", int'(e.kind)), pack(k, v, cyc),
            pack(e.kind, e.val, e.cy));
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en && rstn_i) begin
      check("gnt_onehot",  64'($countones(gnt_o)  <= 1), 64'd1);
      check("done_onehot", 64'($countones(done_o) <= 1), 64'd1);
      check("err_implies_done", 64'(err_o & ~|done_o), 64'd0);
      if (gnt_o != 2'b00 && gnt_o != prev_gnt) observe(EV_GRANT, {sel_o, gnt_o});
      if (imc_start_o)                         observe(EV_START, {2'b00, sel_o});
      if (done_o != 2'b00)                     observe(EV_DONE,  {err_o, done_o});
      if (prev_busy && !busy_o)                observe(EV_IDLE,  3'b000);
    end
    prev_gnt  = gnt_o;
    prev_busy = busy_o;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called in an IDLE cycle with req_i already nonzero. d = extra WAIT cycles
  // before imc_done_i; spur = stray imc_done_i in GRANT/START/RELEASE;
  // drop = owner lowers its request in WAIT; raise_other = the other
  // requester raises its request in WAIT. Returns in the next IDLE cycle.
  task automatic txn(input int d, input bit spur, input bit drop,
                     input bit raise_other);
    bit w;
    bit abort;
    int c, n, rel;
    w     = pick(req_i, last_m);
    c     = cyc;
    abort = WD_ON && (d >= T_OUT);
    n     = c + 3 + d;
    rel   = abort ? c + 3 + T_OUT : n + 1;
    expect_ev(EV_GRANT, {w, onehot(w)}, c + 1);
    expect_ev(EV_START, {2'b00, w}, c + 2);
    expect_ev(EV_DONE,  {abort, onehot(w)}, rel);
    expect_ev(EV_IDLE,  3'b000, rel + 1);
    tick(); imc_done_i = spur;       // GRANT
    tick(); imc_done_i = spur;       // START
    tick(); imc_done_i = 1'b0;       // first WAIT cycle
    if (drop)        req_i[w]  = 1'b0;
    if (raise_other) req_i[~w] = 1'b1;
    while (cyc < rel) begin
      imc_done_i = !abort && (cyc == n);
      tick();
    end
    imc_done_i = spur;               // RELEASE
    tick();
    imc_done_i = 1'b0;               // IDLE
    last_m = w;
  endtask

  task automatic idle_gap(input int k, input bit spur);
    for (int i = 0; i < k; i++) begin
      imc_done_i = spur && ($urandom_range(0, 1) == 1);
      tick();
    end
    imc_done_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn_i     = 1'b0;
    req_i      = 2'b11;
    imc_done_i = 1'b0;
    #12;
    check("rst_gnt",   64'(gnt_o),       64'd0);
    check("rst_start", 64'(imc_start_o), 64'd0);
    check("rst_done",  64'(done_o),      64'd0);
    check("rst_busy",  64'(busy_o),      64'd0);
    check("rst_err",   64'(err_o),       64'd0);
    check("rst_sel",   64'(sel_o),       64'd0);
    req_i = 2'b00;
    tick();
    rstn_i = 1'b1;
    mon_en = 1'b1;
    tick();

    // Simultaneous requests held: grants alternate 0, 1, 0.
    req_i = 2'b11;
    txn(1, 1'b0, 1'b0, 1'b0);
    txn(1, 1'b0, 1'b0, 1'b0);
    txn(1, 1'b0, 1'b0, 1'b0);
    req_i = 2'b00;
    idle_gap(2, 1'b0);

    // Single request, imc_done_i 6 cycles after the request.
    req_i = 2'b01;
    txn(3, 1'b0, 1'b0, 1'b0);
    req_i = 2'b00;
    idle_gap(2, 1'b0);

    // Pending request from requester 1 during requester 0's WAIT.
    req_i = 2'b01;
    txn(2, 1'b0, 1'b0, 1'b1);
    txn(0, 1'b0, 1'b0, 1'b0);
    req_i = 2'b00;
    idle_gap(1, 1'b0);

    // Stray completions and a dropped request.
    req_i = 2'b01;
    txn(2, 1'b1, 1'b1, 1'b0);
    req_i = 2'b00;
    idle_gap(3, 1'b1);

    if (WD_ON) begin
      req_i = 2'b10;
      txn(T_OUT, 1'b0, 1'b0, 1'b0);       // timeout abort
      req_i = 2'b01;
      txn(T_OUT - 1, 1'b0, 1'b0, 1'b0);   // done on the limit cycle: clean
      txn(T_OUT + 2, 1'b0, 1'b0, 1'b0);   // abort, done never arrives
      req_i = 2'b00;
      idle_gap(1, 1'b0);
    end

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] r;
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                      : (req_i | 2'($urandom_range(1, 3)));
      req_i = r;
      if (req_i == 2'b00) begin
        idle_gap($urandom_range(1, 3), 1'b1);
        req_i = 2'($urandom_range(1, 3));
      end
      txn($urandom_range(0, WD_ON ? T_OUT + 2 : 6),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end
    req_i = 2'b00;
    tick(); tick(); tick();
    mon_en = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Reset in the middle of WAIT: outputs clear at once, no done or err.
    req_i = 2'b10;
    tick(); tick(); tick(); tick();      // GRANT, START, WAIT, WAIT
    check("pre_rst_gnt", 64'(gnt_o), 64'd2);
    rstn_i = 1'b0;
    #1;
    check("mid_rst_gnt",  64'(gnt_o),  64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_sel",  64'(sel_o),  64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    imc_done_i = 1'b1;
    tick();
    imc_done_i = 1'b0;
    check("in_rst_done", 64'({done_o, err_o, imc_start_o}), 64'd0);
    rstn_i = 1'b1;
    req_i  = 2'b11;
    tick();
    check("post_rst_gnt", 64'({sel_o, gnt_o}), 64'd1);
    tick();
    check("post_rst_start", 64'(imc_start_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
